// File: rtl/pwm_setting_sequencer.sv
// Button-driven PWM frequency/duty code sequencer: debounced targets, codes applied on period edges.
// Optional soft-start duty ramp is enabled by defining PWM_SOFTSTART_EN.
module pwm_setting_sequencer #(
    parameter int unsigned DEB_CYCLES   = 50000,
    parameter int unsigned RAMP_PERIODS = 4
) (
    input  logic       CLKin,
    input  logic       rst,
    input  logic       btn_cf_up,
    input  logic       btn_cf_dn,
    input  logic       btn_cc_up,
    input  logic       btn_cc_dn,
    input  logic       period_end,
    output logic [3:0] Cf,
    output logic [3:0] Cc,
    output logic [3:0] cf_tgt,
    output logic [3:0] cc_tgt,
    output logic       busy
);

    localparam int unsigned DebW = $clog2(DEB_CYCLES + 1);
    localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWaitEdge, StApply} state_e;

    // Bit order: 0 cf_up, 1 cf_dn, 2 cc_up, 3 cc_dn
    logic [3:0]      btn_raw;
    logic [3:0]      sync1_q, sync2_q;
    logic [3:0]      deb_q, deb_d, deb_prev_q;
    logic [DebW-1:0] deb_cnt_q [4];
    logic [DebW-1:0] deb_cnt_d [4];
    logic [3:0]      press;

    state_e     state_q, state_d;
    logic [3:0] cf_q, cf_d, cc_q, cc_d;
    logic [3:0] cf_tgt_q, cf_tgt_d, cc_tgt_q, cc_tgt_d;
    logic       busy_q, busy_d;

`ifdef PWM_SOFTSTART_EN
    localparam int unsigned RampW = $clog2(RAMP_PERIODS + 1);
    localparam logic [RampW-1:0] RampLast = RampW'(RAMP_PERIODS - 1);
    logic [RampW-1:0] ramp_cnt_q, ramp_cnt_d;
`endif

    assign btn_raw = {btn_cc_dn, btn_cc_up, btn_cf_dn, btn_cf_up};
    assign press   = deb_q & ~deb_prev_q;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            deb_d[i]     = deb_q[i];
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DebLast) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        cf_tgt_d = cf_tgt_q;
        cc_tgt_d = cc_tgt_q;
        if (press[0] && !press[1] && cf_tgt_q != 4'd8) begin
            cf_tgt_d = cf_tgt_q + 4'd1;
        end else if (press[1] && !press[0] && cf_tgt_q != 4'd1) begin
            cf_tgt_d = cf_tgt_q - 4'd1;
        end
        if (press[2] && !press[3] && cc_tgt_q != 4'd8) begin
            cc_tgt_d = cc_tgt_q + 4'd1;
        end else if (press[3] && !press[2] && cc_tgt_q != 4'd0) begin
            cc_tgt_d = cc_tgt_q - 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        cf_d    = cf_q;
        cc_d    = cc_q;
`ifdef PWM_SOFTSTART_EN
        ramp_cnt_d = ramp_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (cf_tgt_q != cf_q || cc_tgt_q != cc_q) state_d = StWaitEdge;
            end
            StWaitEdge: begin
                // Applied codes take the targets registered before this cycle.
                if (period_end) begin
                    state_d = StApply;
                    cf_d    = cf_tgt_q;
`ifdef PWM_SOFTSTART_EN
                    if (ramp_cnt_q == RampLast) begin
                        ramp_cnt_d = '0;
                        if (cc_q < cc_tgt_q) begin
                            cc_d = cc_q + 4'd1;
                        end else if (cc_q > cc_tgt_q) begin
                            cc_d = cc_q - 4'd1;
                        end
                    end else begin
                        ramp_cnt_d = ramp_cnt_q + 1'b1;
                    end
`else
                    cc_d = cc_tgt_q;
`endif
                end
            end
            StApply: begin
                if (cf_q == cf_tgt_q && cc_q == cc_tgt_q) begin
                    state_d = StIdle;
                end else begin
                    state_d = StWaitEdge;
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef PWM_SOFTSTART_EN
        if (cc_q == cc_tgt_q) ramp_cnt_d = '0;
`endif
        busy_d = (cf_d != cf_tgt_d) || (cc_d != cc_tgt_d);
    end

    always_ff @(posedge CLKin) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
            state_q    <= StIdle;
            cf_q       <= 4'd1;
            cc_q       <= 4'd0;
            cf_tgt_q   <= 4'd1;
            cc_tgt_q   <= 4'd0;
            busy_q     <= 1'b0;
`ifdef PWM_SOFTSTART_EN
            ramp_cnt_q <= '0;
`endif
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 4; i++) deb_cnt_q[i] <= deb_cnt_d[i];
            state_q    <= state_d;
            cf_q       <= cf_d;
            cc_q       <= cc_d;
            cf_tgt_q   <= cf_tgt_d;
            cc_tgt_q   <= cc_tgt_d;
            busy_q     <= busy_d;
`ifdef PWM_SOFTSTART_EN
            ramp_cnt_q <= ramp_cnt_d;
`endif
        end
    end

    assign Cf     = cf_q;
    assign Cc     = cc_q;
    assign cf_tgt = cf_tgt_q;
    assign cc_tgt = cc_tgt_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_pwm_setting_sequencer.sv
// Directed bench for pwm_setting_sequencer (DEB_CYCLES=4, RAMP_PERIODS=2).
// Expected ramp values follow PWM_SOFTSTART_EN when defined.
module tb_pwm_setting_sequencer;

    logic       CLKin = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'b0000;  // 0 cf_up, 1 cf_dn, 2 cc_up, 3 cc_dn
    logic       period_end = 1'b0;
    logic [3:0] Cf, Cc, cf_tgt, cc_tgt;
    logic       busy;

    int vec_cnt = 0;
    int err_cnt = 0;

`ifdef PWM_SOFTSTART_EN
    localparam bit SoftStart = 1'b1;
`else
    localparam bit SoftStart = 1'b0;
`endif

    pwm_setting_sequencer #(
        .DEB_CYCLES  (4),
        .RAMP_PERIODS(2)
    ) dut (
        .CLKin     (CLKin),
        .rst       (rst),
        .btn_cf_up (btn[0]),
        .btn_cf_dn (btn[1]),
        .btn_cc_up (btn[2]),
        .btn_cc_dn (btn[3]),
        .period_end(period_end),
        .Cf        (Cf),
        .Cc        (Cc),
        .cf_tgt    (cf_tgt),
        .cc_tgt    (cc_tgt),
        .busy      (busy)
    );

    always #5 CLKin = ~CLKin;

    task automatic tick();
        @(posedge CLKin);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn = 4'b0000;
        period_end = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Hold long enough to debounce, then release long enough to debounce back to 0.
    task automatic press(input logic [3:0] mask);
        btn = mask;
        repeat (10) tick();
        btn = 4'b0000;
        repeat (10) tick();
    endtask

    task automatic pulse_pe();
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vec_cnt++; if (Cf !== 4'd1) begin err_cnt++; $display("FAIL reset_cf got %0d want 1", Cf); end
        vec_cnt++; if (Cc !== 4'd0) begin err_cnt++; $display("FAIL reset_cc got %0d want 0", Cc); end
        vec_cnt++; if (cf_tgt !== 4'd1) begin err_cnt++; $display("FAIL reset_cf_tgt got %0d want 1", cf_tgt); end
        vec_cnt++; if (cc_tgt !== 4'd0) begin err_cnt++; $display("FAIL reset_cc_tgt got %0d want 0", cc_tgt); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_cf_press();
        do_reset();
        press(4'b0001);
        vec_cnt++; if (cf_tgt !== 4'd2) begin err_cnt++; $display("FAIL press_cf_tgt got %0d want 2", cf_tgt); end
        vec_cnt++; if (Cf !== 4'd1) begin err_cnt++; $display("FAIL press_cf_held got %0d want 1", Cf); end
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL press_busy got %b want 1", busy); end
        pulse_pe();
        vec_cnt++; if (Cf !== 4'd2) begin err_cnt++; $display("FAIL apply_cf got %0d want 2", Cf); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL apply_busy got %b want 0", busy); end
        tick();
    endtask

    task automatic test_glitch();
        do_reset();
        btn = 4'b0100;
        repeat (2) tick();
        btn = 4'b0000;
        repeat (10) tick();
        vec_cnt++; if (cc_tgt !== 4'd0) begin err_cnt++; $display("FAIL glitch_cc_tgt got %0d want 0", cc_tgt); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL glitch_busy got %b want 0", busy); end
    endtask

    task automatic test_saturation();
        do_reset();
        press(4'b1000);
        press(4'b0010);
        vec_cnt++; if (cc_tgt !== 4'd0) begin err_cnt++; $display("FAIL sat_cc_low got %0d want 0", cc_tgt); end
        vec_cnt++; if (cf_tgt !== 4'd1) begin err_cnt++; $display("FAIL sat_cf_low got %0d want 1", cf_tgt); end
        repeat (9) press(4'b0001);
        vec_cnt++; if (cf_tgt !== 4'd8) begin err_cnt++; $display("FAIL sat_cf_high got %0d want 8", cf_tgt); end
        vec_cnt++; if (Cf !== 4'd1) begin err_cnt++; $display("FAIL sat_cf_held got %0d want 1", Cf); end
        pulse_pe();
        vec_cnt++; if (Cf !== 4'd8) begin err_cnt++; $display("FAIL sat_cf_apply got %0d want 8", Cf); end
        tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        press(4'b0100);
        press(4'b1100);
        vec_cnt++; if (cc_tgt !== 4'd1) begin err_cnt++; $display("FAIL simul_cc_tgt got %0d want 1", cc_tgt); end
        press(4'b0011);
        vec_cnt++; if (cf_tgt !== 4'd1) begin err_cnt++; $display("FAIL simul_cf_tgt got %0d want 1", cf_tgt); end
    endtask

    // Event lands on the 7th edge after the button rises; align period_end with it.
    task automatic test_coincident();
        do_reset();
        press(4'b0001);
        btn = 4'b0001;
        repeat (6) tick();
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
        vec_cnt++; if (Cf !== 4'd2) begin err_cnt++; $display("FAIL coinc_cf got %0d want 2", Cf); end
        vec_cnt++; if (cf_tgt !== 4'd3) begin err_cnt++; $display("FAIL coinc_cf_tgt got %0d want 3", cf_tgt); end
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL coinc_busy got %b want 1", busy); end
        repeat (3) tick();
        btn = 4'b0000;
        repeat (10) tick();
        pulse_pe();
        vec_cnt++; if (Cf !== 4'd3) begin err_cnt++; $display("FAIL coinc_cf_next got %0d want 3", Cf); end
        tick();
    endtask

    task automatic test_ramp();
        logic [3:0] exp_soft [6];
        logic [3:0] exp_cc;
        exp_soft = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3};
        do_reset();
        repeat (3) press(4'b0100);
        vec_cnt++; if (Cc !== 4'd0) begin err_cnt++; $display("FAIL ramp_pre_cc got %0d want 0", Cc); end
        for (int k = 0; k < 6; k++) begin
            pulse_pe();
            exp_cc = SoftStart ? exp_soft[k] : 4'd3;
            vec_cnt++;
            if (Cc !== exp_cc) begin
                err_cnt++;
                $display("FAIL ramp_cc pulse %0d got %0d want %0d", k + 1, Cc, exp_cc);
            end
            if (k == 4) begin
                vec_cnt++;
                if (busy !== SoftStart) begin
                    err_cnt++;
                    $display("FAIL ramp_busy_p5 got %b want %b", busy, SoftStart);
                end
            end
            tick();
        end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL ramp_busy_end got %b want 0", busy); end
    endtask

    task automatic test_redirect();
        logic [3:0] exp_cc;
        do_reset();
        repeat (3) press(4'b0100);
        pulse_pe(); tick();
        pulse_pe(); tick();
        repeat (3) press(4'b1000);
        pulse_pe();
        exp_cc = SoftStart ? 4'd1 : 4'd0;
        vec_cnt++; if (Cc !== exp_cc) begin err_cnt++; $display("FAIL redir_p1 got %0d want %0d", Cc, exp_cc); end
        tick();
        pulse_pe();
        vec_cnt++; if (Cc !== 4'd0) begin err_cnt++; $display("FAIL redir_p2 got %0d want 0", Cc); end
        tick();
    endtask

    task automatic test_reset_mid_ramp();
        logic [3:0] exp_cc;
        do_reset();
        repeat (5) press(4'b0100);
        for (int k = 0; k < 3; k++) begin
            pulse_pe();
            tick();
        end
        pulse_pe();
        exp_cc = SoftStart ? 4'd2 : 4'd5;
        vec_cnt++; if (Cc !== exp_cc) begin err_cnt++; $display("FAIL mid_cc got %0d want %0d", Cc, exp_cc); end
        // Reset lands on the APPLY cycle.
        rst = 1'b1;
        tick();
        vec_cnt++; if (Cc !== 4'd0) begin err_cnt++; $display("FAIL mid_rst_cc got %0d want 0", Cc); end
        vec_cnt++; if (cc_tgt !== 4'd0) begin err_cnt++; $display("FAIL mid_rst_cc_tgt got %0d want 0", cc_tgt); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        vec_cnt++; if (Cf !== 4'd1) begin err_cnt++; $display("FAIL mid_rst_cf got %0d want 1", Cf); end
        rst = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            pulse_pe();
            tick();
            vec_cnt++;
            if (Cc !== 4'd0 || busy !== 1'b0) begin
                err_cnt++;
                $display("FAIL post_rst_pulse %0d got Cc=%0d busy=%b want Cc=0 busy=0", k, Cc, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cf_press();
        test_glitch();
        test_saturation();
        test_simultaneous();
        test_coincident();
        test_ramp();
        test_redirect();
        test_reset_mid_ramp();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/pwm_setting_sequencer.md
PWM_SETTING_SEQUENCER -- requirements
Module: pwm_setting_sequencer

Interface
REQ-001 Parameter DEB_CYCLES, default 50000: consecutive stable cycles required to accept a button level.
REQ-002 Parameter RAMP_PERIODS, default 4: PWM periods per one-step duty change when soft-start is compiled in.
REQ-003 CLKin  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 btn_cf_up / btn_cf_dn  input  1 each  raw asynchronous push buttons, frequency code up/down.
REQ-006 btn_cc_up / btn_cc_dn  input  1 each  raw asynchronous push buttons, duty code up/down.
REQ-007 period_end  input  1  one-cycle pulse from the PWM generator when its period counter wraps to 0.
REQ-008 Cf  output  4  applied frequency code to the PWM generator, range 1..8.
REQ-009 Cc  output  4  applied duty code to the PWM generator, range 0..8.
REQ-010 cf_tgt / cc_tgt  output  4 each  requested codes.
REQ-011 busy  output  1  high while Cf!=cf_tgt or Cc!=cc_tgt.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer and then a debouncer whose level changes only after DEB_CYCLES consecutive equal synchronized samples.
REQ-013 A press event SHALL be a one-cycle pulse on the rising edge of a debounced level; holding a button SHALL produce exactly one event.
REQ-014 cf_tgt SHALL step +1/-1 per event, saturating at 8 and 1; cc_tgt SHALL saturate at 8 and 0.
REQ-015 Simultaneous up and down events for the same field in one cycle SHALL leave that target unchanged.
REQ-016 The FSM SHALL have three states: IDLE, WAIT_EDGE and APPLY.
REQ-017 IDLE -> WAIT_EDGE when any target differs from its applied code; otherwise the FSM stays in IDLE.
REQ-018 WAIT_EDGE -> APPLY on period_end=1; otherwise the FSM stays in WAIT_EDGE.
REQ-019 APPLY SHALL last one cycle, update Cf/Cc, then go to IDLE if both codes match their targets, else to WAIT_EDGE.
REQ-020 Cf and Cc SHALL change only in the cycle after a period_end pulse (1-cycle latency); they SHALL never change mid-period.
REQ-021 Cf SHALL jump directly to cf_tgt in APPLY.
REQ-022 A period_end pulse and a press event in the same cycle: the target SHALL update, and APPLY SHALL use the target value registered before that cycle.
REQ-023 A target change during a ramp SHALL redirect the ramp from the current Cc, with no restart.
REQ-024 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-025 On rst=1 at a clock edge: Cf=1, cf_tgt=1, Cc=0, cc_tgt=0, busy=0, FSM=IDLE, ramp counter=0, debounced levels=0.
REQ-026 Reset SHALL take precedence over every other event, including reset asserted mid-ramp or in APPLY.

Configuration
REQ-027 Macro PWM_SOFTSTART_EN defined: Cc SHALL move one step toward cc_tgt every RAMP_PERIODS period_end pulses, counted in WAIT_EDGE. The ramp counter SHALL clear on each step and whenever Cc==cc_tgt. Cf SHALL still apply on the first period_end.
REQ-028 Macro PWM_SOFTSTART_EN undefined: Cc SHALL jump to cc_tgt on the first period_end, identically to Cf, and no ramp counter SHALL exist.

Verification (DEB_CYCLES=4, RAMP_PERIODS=2 for simulation)
REQ-029 Press btn_cf_up for 10 cycles with period_end idle -> cf_tgt=2, Cf=1, busy=1; pulse period_end -> Cf=2 one cycle later, busy=0.
REQ-030 Glitch btn_cc_up high for 2 cycles -> no event; cc_tgt stays 0.
REQ-031 From reset, press btn_cc_dn and btn_cf_dn -> targets stay 0 and 1 (saturation); press btn_cf_up 9 times -> cf_tgt=8.
REQ-032 With PWM_SOFTSTART_EN, set cc_tgt=3 and pulse period_end 6 times -> Cc goes 0,1,2,3 on pulses 2, 4 and 6; busy drops after pulse 6.
REQ-033 Without PWM_SOFTSTART_EN, the same stimulus -> Cc=3 after the first pulse.
REQ-034 Assert rst while Cc=2 ramping to 5 -> next cycle Cc=0, cc_tgt=0, busy=0, and subsequent period_end pulses cause no change.
